dmux_stream: RTL and testbench

- Registered, flow-controlled demultiplexer.
- Routes one valid/ready input stream of WIDTH-bit beats to one of 2**NB_SEL output channels. Each channel has a 1-entry output buffer.
- Optional packet-lock mode holds the route for all beats of a packet, from first beat through the beat flagged last.
- Sits between a bus master and per-unit command queues in the CPU datapath.

---
 rtl/dmux_stream_pkg.sv | 14 +
 rtl/dmux_stream_slot.sv | 38 +++
 rtl/dmuxn.sv | 15 +
 rtl/dmux_stream.sv | 81 ++++++++
 tb/tb_dmux_stream.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared types and helpers for the dmux_stream demultiplexer.
package dmux_stream_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Low bit of channel k's slice inside the packed out_data bus.
    function automatic int unsigned slice_lo(int unsigned k, int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// Per-channel 1-entry output buffer; a load wins over a same-cycle drain.
module dmux_stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            last_q  <= last_i;
            valid_q <= 1'b1;
        end else if (valid_q && drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dmuxn.sv
// One-hot decoder: steers a single enable to the output picked by sel_i.
module dmuxn #(
    parameter int NB_SEL = 2
) (
    input  logic                   in_i,
    input  logic [NB_SEL-1:0]      sel_i,
    output logic [2**NB_SEL-1:0]   out_o
);

    always_comb begin
        out_o        = '0;
        out_o[sel_i] = in_i;
    end

endmodule

// File: rtl/dmux_stream.sv
// Registered valid/ready demultiplexer with optional per-packet route lock.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int NB_SEL   = 2,
    parameter int WIDTH    = 8,
    parameter int PKT_LOCK = 1,
    localparam int N       = 2**NB_SEL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [NB_SEL-1:0]  sel,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    output logic [N-1:0]       out_last,
    input  logic [N-1:0]       out_ready,
    output logic               busy
);

    state_e            state_q;
    logic [NB_SEL-1:0] lock_sel_q;
    logic [NB_SEL-1:0] route;
    logic              accept;
    logic [N-1:0]      load;
    logic              locked;

    assign locked   = (PKT_LOCK != 0) && (state_q == ST_LOCKED);
    assign route    = locked ? lock_sel_q : sel;
    assign in_ready = ~out_valid[route] | out_ready[route];
    assign accept   = in_valid & in_ready;
    assign busy     = locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
        end else if ((PKT_LOCK != 0) && accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!in_last) begin
                        lock_sel_q <= sel;
                        state_q    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (in_last) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dmuxn #(
        .NB_SEL (NB_SEL)
    ) u_load_dec (
        .in_i  (accept),
        .sel_i (route),
        .out_o (load)
    );

    for (genvar k = 0; k < N; k++) begin : g_slot
        dmux_stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .drain_i (out_ready[k]),
            .data_i  (in_data),
            .last_i  (in_last),
            .data_o  (out_data[slice_lo(k, WIDTH) +: WIDTH]),
            .last_o  (out_last[k]),
            .valid_o (out_valid[k])
        );
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: per-beat (PKT_LOCK=0) and locked (PKT_LOCK=1) instances.
module tb_dmux_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  sel;
    logic [3:0]  out_ready;

    logic        rdy0, rdy1;
    logic [31:0] od0, od1;
    logic [3:0]  ov0, ov1, ol0, ol1;
    logic        busy0, busy1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dmux_stream #(.NB_SEL(2), .WIDTH(8), .PKT_LOCK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .sel(sel), .in_ready(rdy0), .out_data(od0),
        .out_valid(ov0), .out_last(ol0), .out_ready(out_ready), .busy(busy0)
    );

    dmux_stream #(.NB_SEL(2), .WIDTH(8), .PKT_LOCK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .sel(sel), .in_ready(rdy1), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_ready(out_ready), .busy(busy1)
    );

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 4'b0000;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h77; sel = 2'd0; in_last = 1'b1;
        @(negedge clk);
        in_data = 8'h88; sel = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov0 !== 4'b0101) $display("FAIL rst_pre_ov0 got %b exp %b", ov0, 4'b0101);
        else pass_cnt++;
        total_cnt++;
        if (ol1 !== 4'b0101) $display("FAIL rst_pre_ol1 got %b exp %b", ol1, 4'b0101);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ov0 !== 4'b0000) $display("FAIL rst_ov0 got %b exp %b", ov0, 4'b0000);
        else pass_cnt++;
        total_cnt++;
        if (od0 !== 32'h0) $display("FAIL rst_od0 got %h exp %h", od0, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (ov1 !== 4'b0000 || ol1 !== 4'b0000 || od1 !== 32'h0 || busy1 !== 1'b0)
            $display("FAIL rst_dut1 got ov=%b ol=%b od=%h busy=%b exp all 0",
                     ov1, ol1, od1, busy1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_per_beat();
        do_reset();
        out_ready = 4'b1111;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA1; sel = 2'd2; in_last = 1'b0;
        #1;
        total_cnt++;
        if (rdy0 !== 1'b1) $display("FAIL pb_rdy_a got %b exp 1", rdy0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov0 !== 4'b0100 || od0[23:16] !== 8'hA1)
            $display("FAIL pb_a got ov=%b d=%h exp ov=0100 d=a1", ov0, od0[23:16]);
        else pass_cnt++;
        in_data = 8'hB2; sel = 2'd0;
        #1;
        total_cnt++;
        if (rdy0 !== 1'b1) $display("FAIL pb_rdy_b got %b exp 1", rdy0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov0 !== 4'b0001 || od0[7:0] !== 8'hB2)
            $display("FAIL pb_b got ov=%b d=%h exp ov=0001 d=b2", ov0, od0[7:0]);
        else pass_cnt++;
        in_data = 8'hC3; sel = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov0 !== 4'b1000 || od0[31:24] !== 8'hC3)
            $display("FAIL pb_c got ov=%b d=%h exp ov=1000 d=c3", ov0, od0[31:24]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov0 !== 4'b0000) $display("FAIL pb_drain got %b exp 0000", ov0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 4'b1101;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h11; sel = 2'd1; in_last = 1'b0;
        @(negedge clk);
        in_data = 8'h22;
        #1;
        total_cnt++;
        if (rdy0 !== 1'b0) $display("FAIL bp_stall_rdy got %b exp 0", rdy0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov0 !== 4'b0010 || od0[15:8] !== 8'h11)
            $display("FAIL bp_hold got ov=%b d=%h exp ov=0010 d=11", ov0, od0[15:8]);
        else pass_cnt++;
        out_ready = 4'b1111;
        #1;
        total_cnt++;
        if (rdy0 !== 1'b1) $display("FAIL bp_release_rdy got %b exp 1", rdy0);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov0 !== 4'b0010 || od0[15:8] !== 8'h22)
            $display("FAIL bp_second got ov=%b d=%h exp ov=0010 d=22", ov0, od0[15:8]);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov0 !== 4'b0000) $display("FAIL bp_drain got %b exp 0000", ov0);
        else pass_cnt++;
    endtask

    task automatic test_pkt_lock();
        do_reset();
        out_ready = 4'b1111;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h10; sel = 2'd1; in_last = 1'b0;
        #1;
        total_cnt++;
        if (busy1 !== 1'b0) $display("FAIL pl_busy_pre got %b exp 0", busy1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ov1 !== 4'b0010 || od1[15:8] !== 8'h10 || busy1 !== 1'b1)
            $display("FAIL pl_b0 got ov=%b d=%h busy=%b exp ov=0010 d=10 busy=1",
                     ov1, od1[15:8], busy1);
        else pass_cnt++;
        total_cnt++;
        if (busy0 !== 1'b0) $display("FAIL pl_busy_nolock got %b exp 0", busy0);
        else pass_cnt++;
        in_data = 8'h20; sel = 2'd3;
        @(negedge clk);
        total_cnt++;
        if (ov1 !== 4'b0010 || od1[15:8] !== 8'h20 || busy1 !== 1'b1)
            $display("FAIL pl_b1 got ov=%b d=%h busy=%b exp ov=0010 d=20 busy=1",
                     ov1, od1[15:8], busy1);
        else pass_cnt++;
        in_data = 8'h30; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov1 !== 4'b0010 || od1[15:8] !== 8'h30 || ol1 !== 4'b0010 || busy1 !== 1'b0)
            $display("FAIL pl_b2 got ov=%b d=%h l=%b busy=%b exp ov=0010 d=30 l=0010 busy=0",
                     ov1, od1[15:8], ol1, busy1);
        else pass_cnt++;
    endtask

    task automatic test_single_beat();
        do_reset();
        out_ready = 4'b1110;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; sel = 2'd0; in_last = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy1 !== 1'b0 || ov1 !== 4'b0001)
            $display("FAIL sb_first got busy=%b ov=%b exp busy=0 ov=0001", busy1, ov1);
        else pass_cnt++;
        in_data = 8'h6B; sel = 2'd2;
        #1;
        total_cnt++;
        if (rdy1 !== 1'b1) $display("FAIL sb_rdy got %b exp 1", rdy1);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov1 !== 4'b0101 || od1[23:16] !== 8'h6B || od1[7:0] !== 8'h5A || busy1 !== 1'b0)
            $display("FAIL sb_indep got ov=%b d2=%h d0=%h busy=%b exp ov=0101 d2=6b d0=5a busy=0",
                     ov1, od1[23:16], od1[7:0], busy1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pkt();
        do_reset();
        out_ready = 4'b0111;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h99; sel = 2'd3; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (busy1 !== 1'b1 || ov1 !== 4'b1000)
            $display("FAIL rm_locked got busy=%b ov=%b exp busy=1 ov=1000", busy1, ov1);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy1 !== 1'b0 || ov1 !== 4'b0000)
            $display("FAIL rm_reset got busy=%b ov=%b exp busy=0 ov=0000", busy1, ov1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'b0110;
        in_valid = 1'b1; in_data = 8'h42; sel = 2'd0; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (ov1 !== 4'b0001 || od1[7:0] !== 8'h42)
            $display("FAIL rm_reroute got ov=%b d=%h exp ov=0001 d=42", ov1, od1[7:0]);
        else pass_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sel       = 2'd0;
        out_ready = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_per_beat();
        test_backpressure();
        test_pkt_lock();
        test_single_beat();
        test_reset_mid_pkt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
